// File: rtl/crc_sched_pkg.sv
// -----------------------------------------------------------------------------
// crc_sched_pkg
// Shared definitions for the CRC frame scheduler: default payload/CRC widths,
// the derived frame size in bytes, and the scheduler state encoding.
// -----------------------------------------------------------------------------
package crc_sched_pkg;

   localparam int DATA_W_DEF = 48;
   localparam int CRC_W_DEF  = 8;
   localparam int FRAME_W    = DATA_W_DEF + CRC_W_DEF;
   localparam int NBYTES     = FRAME_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SEND  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage : crc_sched_pkg

// File: rtl/crc_frame_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The first set request at or after the
// pointer wins, wrapping modulo N_REQ. The pointer register lives in the parent.
//
// Ports:
//   req        in   N_REQ   request vector
//   ptr        in   PTR_W   index with highest priority this round
//   grant_oh   out  N_REQ   one-hot grant (all zero when nothing requested)
//   grant_idx  out  PTR_W   binary index of the granted requester
//   grant_vld  out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant_oh,
   output logic [PTR_W-1:0] grant_idx,
   output logic             grant_vld
);

   always_comb begin
      // NOTE: every output gets a default before any conditional assignment, so no path leaves one unassigned and no latch is inferred.
      grant_oh  = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      // First pass: indices at or after the pointer.
      for (int i = 0; i < N_REQ; i++) begin
         if (!grant_vld && req[i] && (i >= int'(ptr))) begin
            grant_vld   = 1'b1;
            grant_oh[i] = 1'b1;
            grant_idx   = PTR_W'(i);
         end
      end
      // Second pass: wrap around to indices below the pointer.
      for (int i = 0; i < N_REQ; i++) begin
         if (!grant_vld && req[i] && (i < int'(ptr))) begin
            grant_vld   = 1'b1;
            grant_oh[i] = 1'b1;
            grant_idx   = PTR_W'(i);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/crc_frame_sched.sv
// -----------------------------------------------------------------------------
// crc_frame_sched
// Shares one CRC-8 frame generator between N_REQ result producers. It grants
// a requester round-robin and holds its payload on crc_data while the CRC
// unit runs. It then captures the {payload, crc} frame and streams it
// MSB-byte-first over a valid/ready byte handshake. The winner is acked when
// its frame has been fully sent, or when the CRC unit times out.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req            per-requester level request, held until its ack
//   req_data       payloads, requester i at [i*DATA_W +: DATA_W]
//   ack            one-cycle pulse per requester: frame sent or dropped
//   crc_en         one-cycle start pulse to the CRC unit
//   crc_data       payload to the CRC unit, stable until the frame is captured
//   crc_done       CRC unit completion pulse (only honoured while waiting)
//   crc_frame      CRC unit output {payload, crc}
//   tx_valid       byte valid to the UART
//   tx_byte        byte to the UART
//   tx_ready       UART accepts tx_byte when tx_valid & tx_ready
//   busy           high whenever the scheduler is not idle
//   err_timeout    one-cycle pulse when the CRC unit fails to answer
//   frames_sent    completed frame count, wraps at 16 bits
// -----------------------------------------------------------------------------
module crc_frame_sched
   import crc_sched_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CRC_W   = CRC_W_DEF,
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic                    crc_en,
   output logic [DATA_W-1:0]       crc_data,
   input  logic                    crc_done,
   input  logic [DATA_W+CRC_W-1:0] crc_frame,
   output logic                    tx_valid,
   output logic [7:0]              tx_byte,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic                    err_timeout,
   output logic [15:0]             frames_sent
);

   localparam int SR_W    = DATA_W + CRC_W;
   localparam int N_BYTES = SR_W / 8;
   localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int TMR_W   = $clog2(TIMEOUT + 1);
   localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e              state_q,       state_d;
   logic [PTR_W-1:0]    ptr_q,         ptr_d;
   logic [PTR_W-1:0]    grant_q,       grant_d;
   logic [DATA_W-1:0]   crc_data_q,    crc_data_d;
   logic [SR_W-1:0]     shreg_q,       shreg_d;
   logic [IDX_W-1:0]    idx_q,         idx_d;
   logic [TMR_W-1:0]    tmr_q,         tmr_d;
   logic [15:0]         frames_sent_q, frames_sent_d;

   logic [N_REQ-1:0]    arb_oh;
   logic [PTR_W-1:0]    arb_idx;
   logic                arb_vld;
   logic [N_REQ-1:0]    grant_dec;
   logic [PTR_W-1:0]    ptr_next;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req       (req),
      .ptr       (ptr_q),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx),
      .grant_vld (arb_vld)
   );

   // Ack targets the latched winner, not whoever is requesting now.
   assign grant_dec = N_REQ'(1) << grant_q;
   // Priority moves past the winner, wrapping modulo N_REQ.
   assign ptr_next  = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      crc_data_d    = crc_data_q;
      shreg_d       = shreg_q;
      idx_d         = idx_q;
      tmr_d         = tmr_q;
      frames_sent_d = frames_sent_q;
      crc_en        = 1'b0;
      tx_valid      = 1'b0;
      ack           = '0;
      err_timeout   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               grant_d = arb_idx;
               for (int i = 0; i < N_REQ; i++) begin
                  if (arb_oh[i]) begin
                     crc_data_d = req_data[i*DATA_W +: DATA_W];
                  end
               end
               state_d = ST_START;
            end
         end

         ST_START: begin
            crc_en  = 1'b1;
            tmr_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // A completion in the same cycle as the limit still counts as done.
            if (crc_done) begin
               shreg_d = crc_frame;
               idx_d   = '0;
               state_d = ST_SEND;
            end else if (tmr_q == TMR_W'(TIMEOUT)) begin
               err_timeout = 1'b1;
               ack         = grant_dec;
               ptr_d       = ptr_next;
               state_d     = ST_IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         ST_SEND: begin
            tx_valid = 1'b1;
            // The shift register only moves on acceptance, which keeps tx_byte stable under back-pressure.
            if (tx_ready) begin
               shreg_d = shreg_q << 8;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(N_BYTES - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            ack           = grant_dec;
            frames_sent_d = frames_sent_q + 16'd1;
            ptr_d         = ptr_next;
            state_d       = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         grant_q       <= '0;
         crc_data_q    <= '0;
         shreg_q       <= '0;
         idx_q         <= '0;
         tmr_q         <= '0;
         frames_sent_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         crc_data_q    <= crc_data_d;
         shreg_q       <= shreg_d;
         idx_q         <= idx_d;
         tmr_q         <= tmr_d;
         frames_sent_q <= frames_sent_d;
      end
   end

   assign crc_data    = crc_data_q;
   assign tx_byte     = shreg_q[SR_W-1 -: 8];
   assign busy        = (state_q != ST_IDLE);
   assign frames_sent = frames_sent_q;

endmodule : crc_frame_sched

// File: tb/tb_crc_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_sched
// Directed bench for crc_frame_sched. A stub CRC unit answers crc_en with
// {payload, 8'hA5} after a fixed latency, or stays silent to force a timeout.
// A monitor logs accepted bytes, acks, crc_en and err_timeout events; each
// scenario task drives stimulus and compares the logs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_crc_frame_sched;

   localparam int DATA_W  = 48;
   localparam int CRC_W   = 8;
   localparam int N_REQ   = 2;
   localparam int TIMEOUT = 255;
   localparam int FRM_W   = DATA_W + CRC_W;
   localparam int N_BYTES = FRM_W / 8;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [N_REQ-1:0]        req = '0;
   logic [N_REQ*DATA_W-1:0] req_data = '0;
   logic [N_REQ-1:0]        ack;
   logic                    crc_en;
   logic [DATA_W-1:0]       crc_data;
   logic                    crc_done = 1'b0;
   logic [FRM_W-1:0]        crc_frame = '0;
   logic                    tx_valid;
   logic [7:0]              tx_byte;
   logic                    tx_ready = 1'b0;
   logic                    busy;
   logic                    err_timeout;
   logic [15:0]             frames_sent;

   crc_frame_sched #(
      .DATA_W  (DATA_W),
      .CRC_W   (CRC_W),
      .N_REQ   (N_REQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .crc_en      (crc_en),
      .crc_data    (crc_data),
      .crc_done    (crc_done),
      .crc_frame   (crc_frame),
      .tx_valid    (tx_valid),
      .tx_byte     (tx_byte),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .err_timeout (err_timeout),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Event logs filled by the monitor.
   logic [7:0]        byte_log[$];
   logic [N_REQ-1:0]  ack_log[$];
   logic [DATA_W-1:0] crc_data_log[$];
   int cyc = 0;
   int crc_en_cnt, crc_en_cyc, to_cnt, to_cyc, ack_cyc, txv_cnt, stall_cnt, stall_viol;
   logic       stall_pend = 1'b0;
   logic [7:0] stall_byte = '0;

   bit stub_respond = 1'b1;
   int stub_lat = 40;
   logic [DATA_W-1:0] stub_payload;

   // Stub CRC unit.
   initial begin
      forever begin
         @(negedge clk);
         if (crc_en && !rst && stub_respond) begin
            stub_payload = crc_data;
            repeat (stub_lat) @(negedge clk);
            crc_frame = {stub_payload, 8'hA5};
            crc_done  = 1'b1;
            @(negedge clk);
            crc_done  = 1'b0;
         end
      end
   end

   // Monitor: samples 1 ns before each rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!rst) begin
            if (stall_pend && tx_valid && (tx_byte !== stall_byte)) stall_viol++;
            stall_pend = tx_valid && !tx_ready;
            stall_byte = tx_byte;
            if (tx_valid && !tx_ready) stall_cnt++;
            if (tx_valid && tx_ready) byte_log.push_back(tx_byte);
            if (tx_valid) txv_cnt++;
            if (crc_en) begin
               crc_en_cnt++;
               crc_en_cyc = cyc;
               crc_data_log.push_back(crc_data);
            end
            if (ack != '0) begin
               ack_log.push_back(ack);
               ack_cyc = cyc;
            end
            if (err_timeout) begin
               to_cnt++;
               to_cyc = cyc;
            end
         end else begin
            stall_pend = 1'b0;
         end
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      byte_log.delete();
      ack_log.delete();
      crc_data_log.delete();
      crc_en_cnt = 0; crc_en_cyc = 0; to_cnt = 0; to_cyc = 0; ack_cyc = 0;
      txv_cnt = 0; stall_cnt = 0; stall_viol = 0; stall_pend = 1'b0;
   endtask

   task automatic do_reset();
      req      = '0;
      tx_ready = 1'b0;
      #1 rst   = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Waits for n ack pulses, then drops every request in that same cycle.
   task automatic wait_acks(input int n, input int bound, input string name);
      int got = 0;
      int k   = 0;
      while (got < n && k < bound) begin
         @(negedge clk);
         k++;
         if (ack != '0) got++;
      end
      req = '0;
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL %s: acks seen %0d, required %0d within %0d cycles", name, got, n, bound);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (tx_valid !== 1'b0)    begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      checks++; if (crc_en !== 1'b0)      begin errors++; $display("FAIL reset_crc_en: got %b want 0", crc_en); end
      checks++; if (ack !== 2'b00)        begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames_sent: got %0d want 0", frames_sent); end
      checks++; if (crc_data !== 48'd0)   begin errors++; $display("FAIL reset_crc_data: got %h want 0", crc_data); end
      checks++; if (tx_byte !== 8'd0)     begin errors++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      // A stray crc_done in IDLE must not move the FSM.
      crc_done = 1'b1;
      @(negedge clk);
      crc_done = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL stray_done_busy: got %b want 0", busy); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stray_done_tx_valid: got %b want 0", tx_valid); end
   endtask

   task automatic test_single();
      logic [7:0] exp_b [7] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hA5};
      int req_cyc;
      clear_logs();
      req_data[0*DATA_W +: DATA_W] = 48'h123456789ABC;
      tx_ready = 1'b1;
      @(negedge clk);
      req_cyc = cyc;
      req = 2'b01;
      wait_acks(1, 200, "single_ack");
      @(negedge clk);
      checks++; if (crc_en_cnt != 1) begin errors++; $display("FAIL single_crc_en_count: got %0d want 1", crc_en_cnt); end
      checks++; if (crc_en_cyc - req_cyc != 1) begin errors++; $display("FAIL single_crc_en_latency: got %0d want 1", crc_en_cyc - req_cyc); end
      if (crc_data_log.size() > 0) begin
         checks++; if (crc_data_log[0] !== 48'h123456789ABC) begin errors++; $display("FAIL single_crc_data: got %h want 123456789abc", crc_data_log[0]); end
      end
      checks++; if (byte_log.size() != N_BYTES) begin errors++; $display("FAIL single_byte_count: got %0d want 7", byte_log.size()); end
      for (int i = 0; i < byte_log.size() && i < N_BYTES; i++) begin
         checks++;
         if (byte_log[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, byte_log[i], exp_b[i]); end
      end
      checks++; if (ack_log.size() != 1) begin errors++; $display("FAIL single_ack_count: got %0d want 1", ack_log.size()); end
      if (ack_log.size() > 0) begin
         checks++; if (ack_log[0] !== 2'b01) begin errors++; $display("FAIL single_ack_value: got %b want 01", ack_log[0]); end
      end
      checks++; if (ack_cyc - crc_en_cyc != 48) begin errors++; $display("FAIL single_ack_latency: got %0d want 48", ack_cyc - crc_en_cyc); end
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames_sent: got %0d want 1", frames_sent); end
   endtask

   task automatic test_round_robin();
      logic [DATA_W-1:0] pa = 48'hAAAA_0000_0001;
      logic [DATA_W-1:0] pb = 48'hBBBB_0000_0002;
      logic [DATA_W-1:0] exp_pay [3];
      logic [N_REQ-1:0]  exp_ack [3] = '{2'b01, 2'b10, 2'b01};
      exp_pay = '{pa, pb, pa};
      do_reset();
      clear_logs();
      stub_lat = 5;
      req_data = {pb, pa};
      tx_ready = 1'b1;
      req = 2'b11;
      wait_acks(3, 200, "rr_acks");
      @(negedge clk);
      checks++; if (ack_log.size() != 3) begin errors++; $display("FAIL rr_ack_count: got %0d want 3", ack_log.size()); end
      for (int i = 0; i < ack_log.size() && i < 3; i++) begin
         checks++;
         if (ack_log[i] !== exp_ack[i]) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", i, ack_log[i], exp_ack[i]); end
      end
      for (int i = 0; i < crc_data_log.size() && i < 3; i++) begin
         checks++;
         if (crc_data_log[i] !== exp_pay[i]) begin errors++; $display("FAIL rr_grant%0d_payload: got %h want %h", i, crc_data_log[i], exp_pay[i]); end
      end
      checks++; if (byte_log.size() != 3*N_BYTES) begin errors++; $display("FAIL rr_byte_count: got %0d want 21", byte_log.size()); end
      checks++; if (frames_sent !== 16'd3) begin errors++; $display("FAIL rr_frames_sent: got %0d want 3", frames_sent); end
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] p = 48'hFEDCBA987654;
      logic [FRM_W-1:0]  f;
      int got = 0;
      int k   = 0;
      f = {p, 8'hA5};
      clear_logs();
      req_data[1*DATA_W +: DATA_W] = p;
      req = 2'b10;
      while (got == 0 && k < 300) begin
         @(negedge clk);
         k++;
         tx_ready = ~tx_ready;
         if (ack != '0) got++;
      end
      req = '0;
      tx_ready = 1'b1;
      checks++; if (got != 1) begin errors++; $display("FAIL stall_ack_timeout: acks %0d want 1", got); end
      @(negedge clk);
      checks++; if (stall_cnt == 0) begin errors++; $display("FAIL stall_occurred: stalled cycles %0d want >0", stall_cnt); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_byte_stable: changes %0d want 0", stall_viol); end
      checks++; if (byte_log.size() != N_BYTES) begin errors++; $display("FAIL stall_byte_count: got %0d want 7", byte_log.size()); end
      for (int i = 0; i < byte_log.size() && i < N_BYTES; i++) begin
         checks++;
         if (byte_log[i] !== f[FRM_W-1-8*i -: 8]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, byte_log[i], f[FRM_W-1-8*i -: 8]); end
      end
      if (ack_log.size() > 0) begin
         checks++; if (ack_log[0] !== 2'b10) begin errors++; $display("FAIL stall_ack_value: got %b want 10", ack_log[0]); end
      end
      checks++; if (frames_sent !== 16'd4) begin errors++; $display("FAIL stall_frames_sent: got %0d want 4", frames_sent); end
   endtask

   task automatic test_timeout();
      logic [DATA_W-1:0] p = 48'h001122334455;
      logic [FRM_W-1:0]  f;
      f = {p, 8'hA5};
      clear_logs();
      stub_respond = 1'b0;
      req_data[0*DATA_W +: DATA_W] = 48'hDEAD_BEEF_0000;
      req = 2'b01;
      wait_acks(1, 400, "timeout_ack");
      @(negedge clk);
      checks++; if (to_cnt != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", to_cnt); end
      checks++; if (to_cyc - crc_en_cyc != TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", to_cyc - crc_en_cyc, TIMEOUT + 1); end
      checks++; if (ack_cyc != to_cyc) begin errors++; $display("FAIL timeout_ack_cycle: got %0d want %0d", ack_cyc, to_cyc); end
      if (ack_log.size() > 0) begin
         checks++; if (ack_log[0] !== 2'b01) begin errors++; $display("FAIL timeout_ack_value: got %b want 01", ack_log[0]); end
      end
      checks++; if (txv_cnt != 0) begin errors++; $display("FAIL timeout_tx_valid: cycles %0d want 0", txv_cnt); end
      checks++; if (frames_sent !== 16'd4) begin errors++; $display("FAIL timeout_frames_sent: got %0d want 4", frames_sent); end
      // Recovery: next request served normally.
      stub_respond = 1'b1;
      clear_logs();
      req_data[0*DATA_W +: DATA_W] = p;
      req = 2'b01;
      wait_acks(1, 200, "after_timeout_ack");
      @(negedge clk);
      checks++; if (byte_log.size() != N_BYTES) begin errors++; $display("FAIL after_timeout_byte_count: got %0d want 7", byte_log.size()); end
      for (int i = 0; i < byte_log.size() && i < N_BYTES; i++) begin
         checks++;
         if (byte_log[i] !== f[FRM_W-1-8*i -: 8]) begin errors++; $display("FAIL after_timeout_byte%0d: got %h want %h", i, byte_log[i], f[FRM_W-1-8*i -: 8]); end
      end
      checks++; if (to_cnt != 0) begin errors++; $display("FAIL after_timeout_err: got %0d want 0", to_cnt); end
      checks++; if (frames_sent !== 16'd5) begin errors++; $display("FAIL after_timeout_frames_sent: got %0d want 5", frames_sent); end
   endtask

   task automatic test_reset_mid_send();
      logic [DATA_W-1:0] p = 48'h5A5A0F0FC3C3;
      logic [FRM_W-1:0]  f;
      int k = 0;
      f = {p, 8'hA5};
      clear_logs();
      req_data[0*DATA_W +: DATA_W] = 48'hA1B2C3D4E5F6;
      tx_ready = 1'b1;
      req = 2'b01;
      while (byte_log.size() < 3 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL midrst_in_send: tx_valid %b want 1", tx_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (tx_valid !== 1'b0)     begin errors++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (tx_byte !== 8'd0)      begin errors++; $display("FAIL midrst_tx_byte: got %h want 00", tx_byte); end
      checks++; if (crc_data !== 48'd0)    begin errors++; $display("FAIL midrst_crc_data: got %h want 0", crc_data); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL midrst_frames_sent: got %0d want 0", frames_sent); end
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clear_logs();
      req_data[1*DATA_W +: DATA_W] = p;
      req = 2'b10;
      wait_acks(1, 200, "midrst_recover_ack");
      @(negedge clk);
      checks++; if (byte_log.size() != N_BYTES) begin errors++; $display("FAIL midrst_byte_count: got %0d want 7", byte_log.size()); end
      for (int i = 0; i < byte_log.size() && i < N_BYTES; i++) begin
         checks++;
         if (byte_log[i] !== f[FRM_W-1-8*i -: 8]) begin errors++; $display("FAIL midrst_byte%0d: got %h want %h", i, byte_log[i], f[FRM_W-1-8*i -: 8]); end
      end
      if (ack_log.size() > 0) begin
         checks++; if (ack_log[0] !== 2'b10) begin errors++; $display("FAIL midrst_ack_value: got %b want 10", ack_log[0]); end
      end
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL midrst_frames_sent: got %0d want 1", frames_sent); end
   endtask

   task automatic test_wrap();
      force dut.frames_sent_q = 16'hFFFF;
      repeat (2) @(negedge clk);
      release dut.frames_sent_q;
      @(negedge clk);
      checks++; if (frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", frames_sent); end
      clear_logs();
      req_data[0*DATA_W +: DATA_W] = 48'hC0FFEE123456;
      req = 2'b01;
      wait_acks(1, 200, "wrap_ack");
      @(negedge clk);
      checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", frames_sent); end
      checks++; if (byte_log.size() != N_BYTES) begin errors++; $display("FAIL wrap_byte_count: got %0d want 7", byte_log.size()); end
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_timeout();
      test_reset_mid_send();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_crc_frame_sched
